// File: rtl/i2s_tx_framer.sv
`default_nettype none
// ============================================================================
// Module : i2s_tx_framer
// Desc   : I2S master transmitter. Buffers stereo PCM pairs in a FIFO and
//          serializes Philips-format frames. Optional: I2S_TX_HOLD_ON_UNDERRUN_EN
// Rev    : 1.0  initial release
// ============================================================================
module i2s_tx_framer #(
  parameter int BCLK_DIV    = 4,
  parameter int FIFO_AW     = 3,
  parameter int PRIME_LEVEL = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               audio_en,
  input  logic               status_clr,
  input  logic               l_data_en,
  input  logic               r_data_en,
  input  logic [23:0]        l_data,
  input  logic [23:0]        r_data,
  output logic               bclk,
  output logic               lrclk,
  output logic               s_data,
  output logic               frame_stb,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overrun,
  output logic               underrun
);

  localparam int                 c_depth    = 2 ** FIFO_AW;
  localparam int                 c_div_w    = $clog2(BCLK_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);
  localparam logic [FIFO_AW:0]   c_full     = (FIFO_AW + 1)'(c_depth);
  localparam logic [FIFO_AW:0]   c_prime    = (FIFO_AW + 1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [23:0]          r_hold;
  logic [47:0]          r_mem [c_depth];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_level;
  logic [c_div_w-1:0]   r_div;
  logic [5:0]           r_bit;
  logic                 r_bclk;
  logic                 r_lrclk;
  logic                 r_sdata;
  logic                 r_stb;
  logic [47:0]          r_word;
  logic                 r_ovr;
  logic                 r_und;

  logic                 w_run;
  logic                 w_fall;
  logic                 w_pop_evt;
  logic                 w_active;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_req;
  logic                 w_wr;
  logic                 w_pop;
  logic                 w_ovr_set;
  logic                 w_und_set;
  logic [23:0]          w_hold_next;
  logic [5:0]           w_bit_next;
  logic [4:0]           w_p;
  logic [4:0]           w_bit_idx;
  logic [23:0]          w_half;
  logic                 w_sdata_next;
  logic [47:0]          w_underrun_word;
  logic [FIFO_AW:0]     w_level_next;

  assign w_run     = (r_state == ST_RUN);
  assign w_fall    = w_run && (r_div == c_div_last) && r_bclk;
  assign w_pop_evt = w_fall && (r_bit == 6'd63);
  assign w_active  = audio_en && (r_state != ST_IDLE);
  assign w_full    = (r_level == c_full);
  assign w_empty   = (r_level == '0);
  assign w_wr_req  = w_active && r_data_en;
  assign w_wr      = w_wr_req && !w_full;
  assign w_ovr_set = w_wr_req && w_full;
  assign w_pop     = audio_en && w_pop_evt && !w_empty;
  assign w_und_set = audio_en && w_pop_evt && w_empty;

  // A same-cycle left strobe travels with the right sample
  assign w_hold_next = l_data_en ? l_data : r_hold;

  // Serial bit for the slot position reached at the next falling bclk edge
  assign w_bit_next   = r_bit + 6'd1;
  assign w_p          = w_bit_next[4:0];
  assign w_bit_idx    = 5'd24 - w_p;
  assign w_half       = w_bit_next[5] ? r_word[23:0] : r_word[47:24];
  assign w_sdata_next = ((w_p != 5'd0) && (w_p <= 5'd24)) ? w_half[w_bit_idx] : 1'b0;

`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
  assign w_underrun_word = r_word;
`else
  assign w_underrun_word = '0;
`endif

  always_comb begin
    w_level_next = r_level;
    case ({w_wr, w_pop})
      2'b10:   w_level_next = r_level + (FIFO_AW + 1)'(1);
      2'b01:   w_level_next = r_level - (FIFO_AW + 1)'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (!audio_en) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_PRIME;
        ST_PRIME: if (r_level >= c_prime) w_state_next = ST_RUN;
        ST_RUN:   w_state_next = ST_RUN;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_hold_next, r_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_div    <= '0;
      r_bit    <= '0;
      r_bclk   <= 1'b0;
      r_lrclk  <= 1'b0;
      r_sdata  <= 1'b0;
      r_stb    <= 1'b0;
      r_word   <= '0;
      r_ovr    <= 1'b0;
      r_und    <= 1'b0;
    end else begin
      r_hold <= w_hold_next;
      r_ovr  <= w_ovr_set | (r_ovr & ~status_clr);
      r_und  <= w_und_set | (r_und & ~status_clr);
      r_stb  <= 1'b0;
      if (!audio_en || (r_state == ST_IDLE)) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
        r_div    <= '0;
        r_bit    <= '0;
        r_bclk   <= 1'b0;
        r_lrclk  <= 1'b0;
        r_sdata  <= 1'b0;
        r_word   <= '0;
      end else begin
        if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
        r_level <= w_level_next;
        // Priming preloads bit 63 so the first falling edge wraps and pops
        if (!w_run) begin
          r_div   <= '0;
          r_bit   <= 6'd63;
          r_bclk  <= 1'b0;
          r_lrclk <= 1'b0;
          r_sdata <= 1'b0;
        end else if (r_div == c_div_last) begin
          r_div  <= '0;
          r_bclk <= ~r_bclk;
          if (r_bclk) begin
            r_bit   <= w_bit_next;
            r_lrclk <= w_bit_next[5];
            r_sdata <= w_sdata_next;
            if (w_pop_evt) begin
              r_stb  <= 1'b1;
              r_word <= w_pop ? r_mem[r_rd_ptr] : w_underrun_word;
            end
          end
        end else begin
          r_div <= r_div + c_div_w'(1);
        end
      end
    end
  end

  assign bclk       = r_bclk;
  assign lrclk      = r_lrclk;
  assign s_data     = r_sdata;
  assign frame_stb  = r_stb;
  assign fifo_level = r_level;
  assign overrun    = r_ovr;
  assign underrun   = r_und;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_framer.sv
`default_nettype none
// ============================================================================
// Module : tb_i2s_tx_framer
// Desc   : Self-checking bench for i2s_tx_framer with a frame-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_i2s_tx_framer;

  localparam int D     = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int PL    = 4;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
  localparam logic [23:0] UND_LEFT = 24'hA5A5A5;
`else
  localparam logic [23:0] UND_LEFT = 24'h000000;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          audio_en = 1'b0;
  logic          status_clr = 1'b0;
  logic          l_data_en = 1'b0;
  logic          r_data_en = 1'b0;
  logic [23:0]   l_data = '0;
  logic [23:0]   r_data = '0;
  logic          bclk, lrclk, s_data, frame_stb, overrun, underrun;
  logic [AW:0]   fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  i2s_tx_framer #(.BCLK_DIV(D), .FIFO_AW(AW), .PRIME_LEVEL(PL)) dut (
    .clk(clk), .reset(reset), .audio_en(audio_en), .status_clr(status_clr),
    .l_data_en(l_data_en), .r_data_en(r_data_en), .l_data(l_data), .r_data(r_data),
    .bclk(bclk), .lrclk(lrclk), .s_data(s_data), .frame_stb(frame_stb),
    .fifo_level(fifo_level), .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: state, FIFO queue, time since RUN entry ----------
  logic [47:0] mq[$];
  int          m_st;     // 0 idle, 1 prime, 2 run
  int          m_t;
  logic [23:0] m_hold, m_hold_n, m_half;
  logic [47:0] m_word;
  logic        m_ovr, m_und, m_so, m_su, m_pop;
  int          m_lvl, m_k, m_bc, m_p;
  logic        e_bclk, e_lr, e_sd, e_stb;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete(); m_st = 0; m_t = 0; m_hold = '0; m_word = '0; m_ovr = 0; m_und = 0;
    end else begin
      m_lvl = mq.size(); m_so = 0; m_su = 0;
      m_hold_n = l_data_en ? l_data : m_hold;
      if (!audio_en) begin
        m_st = 0; mq.delete(); m_t = 0; m_word = '0;
      end else begin
        if (m_st != 0 && r_data_en && m_lvl >= DEPTH) m_so = 1;
        m_pop = (m_st == 2) && ((m_t + 1) % (2 * D) == 0) && ((((m_t + 1) / (2 * D)) - 1) % 64 == 0);
        if (m_pop) begin
          if (m_lvl > 0) m_word = mq.pop_front();
          else begin
            m_su = 1;
`ifndef I2S_TX_HOLD_ON_UNDERRUN_EN
            m_word = '0;
`endif
          end
        end
        if (m_st != 0 && r_data_en && m_lvl < DEPTH) mq.push_back({m_hold_n, r_data});
        case (m_st)
          0: m_st = 1;
          1: if (m_lvl >= PL) begin m_st = 2; m_t = 0; end
          default: m_t++;
        endcase
      end
      m_hold = m_hold_n;
      m_ovr = m_so | (m_ovr & ~status_clr);
      m_und = m_su | (m_und & ~status_clr);
    end
    e_bclk = 0; e_lr = 0; e_sd = 0; e_stb = 0;
    if (m_st == 2) begin
      e_bclk = ((m_t / D) % 2) == 1;
      m_k = m_t / (2 * D);
      if (m_k > 0) begin
        m_bc   = (m_k - 1) % 64;
        e_lr   = m_bc >= 32;
        m_p    = m_bc % 32;
        m_half = e_lr ? m_word[23:0] : m_word[47:24];
        e_sd   = (m_p >= 1 && m_p <= 24) ? m_half[24 - m_p] : 1'b0;
        e_stb  = (m_t % (2 * D) == 0) && (m_bc == 0);
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_bclk", bclk, e_bclk);
    chk("cmp_lrclk", lrclk, e_lr);
    chk("cmp_s_data", s_data, e_sd);
    chk("cmp_frame_stb", frame_stb, e_stb);
    chk("cmp_fifo_level", fifo_level, mq.size());
    chk("cmp_overrun", overrun, m_ovr);
    chk("cmp_underrun", underrun, m_und);
  end

  // ---------------- driver helpers -------------------------------------------
  task automatic wr_pair(input logic [23:0] l, input logic [23:0] r);
    l_data_en = 1; r_data_en = 1; l_data = l; r_data = r;
    @(negedge clk);
    l_data_en = 0; r_data_en = 0;
  endtask

  task automatic wait_stb(output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!frame_stb && cnt < 600);
    if (!frame_stb) begin
      n_cmp++; n_err++;
      $display("FAIL wait_stb: no frame_stb within %0d cycles at %0t", cnt, $time);
    end
  endtask

  task automatic wait_bclk(input logic v, output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (bclk !== v && cnt < 50);
  endtask

  task automatic capture(output logic [63:0] sd, output logic [63:0] lr);
    for (int b = 0; b < 64; b++) begin
      sd[b] = s_data; lr[b] = lrclk;
      if (b < 63) repeat (2 * D) @(negedge clk);
    end
  endtask

  function automatic logic [23:0] slot(input logic [63:0] sd, input int base);
    logic [23:0] w;
    w = '0;
    for (int p = 1; p <= 24; p++) w[24 - p] = sd[base + p];
    return w;
  endfunction

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, c2, seen;
    logic [63:0] sd, lr;

    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_level", fifo_level, 0);
    chk("rst_bclk", bclk, 0);
    chk("rst_flags", {overrun, underrun}, 0);

    // Four A5/5A pairs, then starve the FIFO
    audio_en = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) wr_pair(24'hA5A5A5, 24'h5A5A5A);
    wait_stb(c);
    chk("first_pop_latency", c, 9);
    capture(sd, lr);
    chk("second_left_bit", sd[1], 1);
    chk("left_word", slot(sd, 0), 24'hA5A5A5);
    chk("right_word", slot(sd, 32), 24'h5A5A5A);
    chk("left_trail_zero", {sd[31:25], sd[0]}, 0);
    chk("lrclk_left_low", lr[31:0], 32'h0);
    chk("lrclk_right_high", lr[63:32], 32'hFFFFFFFF);
    wait_stb(c);
    wait_stb(c);
    chk("frame_period", c, 128 * D);
    wait_bclk(1, c);
    wait_bclk(0, c1);
    wait_bclk(1, c2);
    chk("bclk_period", c1 + c2, 2 * D);
    wait_stb(c);
    chk("no_underrun_pop4", underrun, 0);
    wait_stb(c);
    chk("underrun_pop5", underrun, 1);
    capture(sd, lr);
    chk("underrun_left_word", slot(sd, 0), UND_LEFT);

    // Flags survive disable; status_clr clears
    audio_en = 0;
    @(negedge clk);
    chk("underrun_kept", underrun, 1);
    chk("disable_level", fifo_level, 0);
    status_clr = 1;
    @(negedge clk);
    status_clr = 0;
    chk("underrun_cleared", underrun, 0);

    // Feed one pair per frame
    audio_en = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) wr_pair(24'h800000, 24'h000001);
    for (int f = 0; f < 6; f++) begin
      wait_stb(c);
      capture(sd, lr);
      chk("rate_left", slot(sd, 0), 24'h800000);
      chk("rate_right", slot(sd, 32), 24'h000001);
      wr_pair(24'h800000, 24'h000001);
      chk("rate_level", fifo_level, 4);
      chk("rate_flags", {overrun, underrun}, 0);
    end

    // Disable mid-frame at bit 40
    wait_stb(c);
    repeat (40 * 2 * D) @(negedge clk);
    chk("lrclk_bit40", lrclk, 1);
    audio_en = 0;
    @(negedge clk);
    chk("drop_outputs", {bclk, lrclk, s_data}, 0);
    chk("drop_level", fifo_level, 0);

    // Re-enable needs a full prime
    audio_en = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) wr_pair(24'h123456 + 24'(i), 24'h654321 + 24'(i));
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bclk || frame_stb) seen = 1;
    end
    chk("prime_hold", seen, 0);
    chk("prime_level", fifo_level, 3);
    wr_pair(24'h123459, 24'h654324);
    wait_stb(c);
    chk("reprime_latency", c, 9);

    // Overrun: ten back-to-back pairs from a fresh prime
    audio_en = 0;
    @(negedge clk);
    audio_en = 1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) wr_pair(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    chk("ovr_level", fifo_level, 8);
    chk("ovr_flag", overrun, 1);
    status_clr = 1;
    @(negedge clk);
    status_clr = 0;
    chk("ovr_cleared", overrun, 0);
    wait_stb(c);
    wait_stb(c);

    // Async reset while running
    for (int i = 0; i < 10; i++) wr_pair(24'h300000 + 24'(i), 24'h400000 + 24'(i));
    chk("ovr_again", overrun, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("async_rst_outputs", {bclk, lrclk, s_data, frame_stb}, 0);
    chk("async_rst_level", fifo_level, 0);
    chk("async_rst_flags", {overrun, underrun}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bclk || frame_stb || fifo_level != 0) seen = 1;
    end
    chk("post_rst_prime", seen, 0);
    for (int i = 0; i < 4; i++) wr_pair(24'h00F00F, 24'hF00F00);
    wait_stb(c);
    chk("post_rst_latency", c, 9);
    wait_stb(c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
